oflow_similarity_scheduler: RTL and testbench

Sequencer for the `oflow_similarity_metric` datapath. For one current-frame object it:
- walks the previous-frame feature buffer entry by entry, one read per cycle;
- feeds each entry to the metric through the buffer read port;
- samples each returned score/id after the metric latency;
- keeps the minimum score and its id, then reports the match with a one-cycle `done` pulse.

It sits between the frame-level tracking control and the metric/feature-buffer pair.

---
 rtl/oflow_similarity_scheduler.sv | 169 ++++++++++++++++
 tb/tb_oflow_similarity_scheduler.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/oflow_similarity_scheduler.sv
// rtl/oflow_similarity_scheduler.sv - walks the previous-frame buffer through the similarity metric and reports the minimum-score match
// Optional threshold/new-object flag enabled by defining OFLOW_SIM_THRESH_EN.
module oflow_similarity_scheduler #(
    parameter int NUM_PREV   = 16,
    parameter int ADDR_W     = $clog2(NUM_PREV),
    parameter int METRIC_LAT = 1,
    parameter int SCORE_W    = 32,
    parameter int ID_W       = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W:0]    num_prev,
    input  logic [SCORE_W-1:0] threshold,
    output logic               prev_rd_en,
    output logic [ADDR_W-1:0]  prev_rd_addr,
    input  logic [SCORE_W-1:0] score,
    input  logic [ID_W-1:0]    id,
    output logic               busy,
    output logic               done,
    output logic [SCORE_W-1:0] best_score,
    output logic [ID_W-1:0]    best_id,
    output logic [ADDR_W-1:0]  best_idx,
    output logic               no_match,
    output logic               new_obj
);

    localparam int DLY = 1 + METRIC_LAT;
    localparam logic [ADDR_W:0] MAX_N = (ADDR_W+1)'(NUM_PREV);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               state;
    logic [ADDR_W:0]      n_clamp;
    logic [ADDR_W-1:0]    last_addr;
    logic [DLY-1:0]       dly_en;
    logic [ADDR_W-1:0]    dly_addr [DLY];
    logic [SCORE_W-1:0]   run_score;
    logic [ID_W-1:0]      run_id;
    logic [ADDR_W-1:0]    run_idx;
    logic                 samp_hit;

    always_comb begin
        n_clamp  = (num_prev > MAX_N) ? MAX_N : num_prev;
        samp_hit = dly_en[DLY-1] && (score < run_score);
    end

    // Read strobe/address travel alongside the buffer read and metric pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            dly_en <= '0;
            for (int i = 0; i < DLY; i++) begin
                dly_addr[i] <= '0;
            end
        end else begin
            dly_en[0]   <= prev_rd_en;
            dly_addr[0] <= prev_rd_addr;
            for (int i = 1; i < DLY; i++) begin
                dly_en[i]   <= dly_en[i-1];
                dly_addr[i] <= dly_addr[i-1];
            end
        end
    end

`ifdef OFLOW_SIM_THRESH_EN
    logic [SCORE_W-1:0] thr_q;
    logic               new_obj_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            thr_q     <= '0;
            new_obj_q <= 1'b0;
        end else begin
            if (state == S_IDLE && start) begin
                thr_q <= threshold;
                if (n_clamp == '0) begin
                    new_obj_q <= 1'b1;
                end
            end else if (state == S_DRAIN && dly_en == '0) begin
                new_obj_q <= (run_score > thr_q);
            end
        end
    end

    assign new_obj = new_obj_q;
`else
    logic unused_threshold;
    assign unused_threshold = ^threshold;
    assign new_obj = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            prev_rd_en   <= 1'b0;
            prev_rd_addr <= '0;
            last_addr    <= '0;
            run_score    <= '1;
            run_id       <= '0;
            run_idx      <= '0;
            best_score   <= '1;
            best_id      <= '0;
            best_idx     <= '0;
            no_match     <= 1'b0;
        end else begin
            done <= 1'b0;
            // Strict less-than over ascending addresses keeps the lowest index on ties
            if (samp_hit) begin
                run_score <= score;
                run_id    <= id;
                run_idx   <= dly_addr[DLY-1];
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        run_score <= '1;
                        run_id    <= '0;
                        run_idx   <= '0;
                        if (n_clamp == '0) begin
                            state      <= S_DONE;
                            done       <= 1'b1;
                            best_score <= '1;
                            best_id    <= '0;
                            best_idx   <= '0;
                            no_match   <= 1'b1;
                        end else begin
                            state        <= S_ISSUE;
                            prev_rd_en   <= 1'b1;
                            prev_rd_addr <= '0;
                            last_addr    <= ADDR_W'(n_clamp - 1'b1);
                        end
                    end
                end
                S_ISSUE: begin
                    if (prev_rd_addr == last_addr) begin
                        prev_rd_en <= 1'b0;
                        state      <= S_DRAIN;
                    end else begin
                        prev_rd_addr <= prev_rd_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (dly_en == '0) begin
                        state      <= S_DONE;
                        done       <= 1'b1;
                        best_score <= run_score;
                        best_id    <= run_id;
                        best_idx   <= run_idx;
                        no_match   <= 1'b0;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oflow_similarity_scheduler.sv
// tb/tb_oflow_similarity_scheduler.sv - directed self-checking bench for oflow_similarity_scheduler
module tb_oflow_similarity_scheduler;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  num_prev;
    logic [31:0] threshold;
    logic        prev_rd_en;
    logic [3:0]  prev_rd_addr;
    logic [31:0] score;
    logic [11:0] id;
    logic        busy;
    logic        done;
    logic [31:0] best_score;
    logic [11:0] best_id;
    logic [3:0]  best_idx;
    logic        no_match;
    logic        new_obj;

    oflow_similarity_scheduler #(
        .NUM_PREV(16), .ADDR_W(4), .METRIC_LAT(LAT), .SCORE_W(32), .ID_W(12)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .num_prev(num_prev),
        .threshold(threshold), .prev_rd_en(prev_rd_en), .prev_rd_addr(prev_rd_addr),
        .score(score), .id(id), .busy(busy), .done(done),
        .best_score(best_score), .best_id(best_id), .best_idx(best_idx),
        .no_match(no_match), .new_obj(new_obj)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sc [16];
    logic [11:0] idv [16];
    logic        hist_en [64];
    logic [3:0]  hist_addr [64];
    int          done_seen;
    int          reads_seen;

    task automatic chk(input string nm, input int t, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d actual=0x%0h expected=0x%0h", nm, t, act, exp);
        end
    endtask

    task automatic load4(input logic [31:0] a, b, c, d, input logic [11:0] id0);
        sc[0] = a; sc[1] = b; sc[2] = c; sc[3] = d;
        for (int k = 0; k < 4; k++) idv[k] = id0 + 12'(k);
    endtask

    task automatic chk_reset_vals(input string tag, input int t);
        chk({tag, "_busy"}, t, 32'(busy), 0);
        chk({tag, "_done"}, t, 32'(done), 0);
        chk({tag, "_rd_en"}, t, 32'(prev_rd_en), 0);
        chk({tag, "_rd_addr"}, t, 32'(prev_rd_addr), 0);
        chk({tag, "_best_score"}, t, best_score, 32'hFFFF_FFFF);
        chk({tag, "_best_id"}, t, 32'(best_id), 0);
        chk({tag, "_best_idx"}, t, 32'(best_idx), 0);
        chk({tag, "_no_match"}, t, 32'(no_match), 0);
        chk({tag, "_new_obj"}, t, 32'(new_obj), 0);
    endtask

    // One search: t counts cycles from the start cycle (t=0); all work done mid-cycle
    task automatic run_search(input int n_in, input logic [31:0] thr, input int restart_t, input int reset_t);
        int          nc, dc, last_t, src;
        logic [31:0] es;
        logic [11:0] ei;
        logic [3:0]  ex;
        logic        eno;
        bit          found;
        nc = (n_in > 16) ? 16 : n_in;
        dc = (nc == 0) ? 1 : nc + 3 + LAT;
        es = '1; ei = '0; ex = '0; found = 0;
        for (int k = 0; k < nc; k++) if (sc[k] < es) es = sc[k];
        for (int k = 0; k < nc; k++) begin
            if (!found && es != 32'hFFFF_FFFF && sc[k] == es) begin
                ei = idv[k]; ex = 4'(k); found = 1;
            end
        end
`ifdef OFLOW_SIM_THRESH_EN
        eno = (es > thr) || (nc == 0);
`else
        eno = 1'b0;
`endif
        last_t = (reset_t > 0) ? reset_t + 3 : dc;
        done_seen = -1;
        reads_seen = 0;
        for (int i = 0; i < 64; i++) begin
            hist_en[i] = 1'b0; hist_addr[i] = '0;
        end
        for (int t = 0; t <= last_t; t++) begin
            @(negedge clk);
            start     = (t == 0) || (t == restart_t);
            num_prev  = 5'(n_in);
            threshold = thr;
            reset     = (reset_t > 0) && (t == reset_t);
            src = t - 1 - LAT;
            if (src >= 0 && hist_en[src]) begin
                score = sc[hist_addr[src]];
                id    = idv[hist_addr[src]];
            end else begin
                score = 32'd0;
                id    = 12'hFFF;
            end
            hist_en[t]   = prev_rd_en;
            hist_addr[t] = prev_rd_addr;
            if (prev_rd_en) reads_seen++;
            if (done && done_seen < 0) done_seen = t;
            if (reset_t > 0 && t > reset_t) begin
                chk_reset_vals("after_reset", t);
            end else begin
                chk("rd_en", t, 32'(prev_rd_en), 32'(t >= 1 && t <= nc));
                if (t >= 1 && t <= nc)
                    chk("rd_addr", t, 32'(prev_rd_addr), 32'(t - 1));
                else if (nc > 0 && t > nc && t <= dc)
                    chk("rd_addr_hold", t, 32'(prev_rd_addr), 32'(nc - 1));
                chk("busy", t, 32'(busy), 32'(t >= 1 && t <= dc));
                chk("done", t, 32'(done), 32'(t == dc));
                if (t == dc) begin
                    chk("best_score", t, best_score, es);
                    chk("best_id", t, 32'(best_id), 32'(ei));
                    chk("best_idx", t, 32'(best_idx), 32'(ex));
                    chk("no_match", t, 32'(no_match), 32'(nc == 0));
                    chk("new_obj", t, 32'(new_obj), 32'(eno));
                end
            end
        end
        start = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; num_prev = '0; threshold = '0; score = '0; id = '0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset", 0);
        reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("idle", 0);

        load4(32'd50, 32'd20, 32'd70, 32'd30, 12'h011);
        run_search(4, 32'd25, -1, 0);
        chk("t1_done_cycle", 0, 32'(done_seen), 32'd8);
        chk("t1_best_score", 0, best_score, 32'd20);
        chk("t1_best_id", 0, 32'(best_id), 32'h012);
        chk("t1_best_idx", 0, 32'(best_idx), 32'd1);
        chk("t1_reads", 0, 32'(reads_seen), 32'd4);

        load4(32'd40, 32'd40, 32'd40, 32'd99, 12'h021);
        run_search(3, 32'd0, -1, 0);
        chk("tie_best_idx", 0, 32'(best_idx), 32'd0);
        chk("tie_best_id", 0, 32'(best_id), 32'h021);

        run_search(0, 32'd5, -1, 0);
        chk("n0_done_cycle", 0, 32'(done_seen), 32'd1);
        chk("n0_no_match", 0, 32'(no_match), 32'd1);
        chk("n0_best_score", 0, best_score, 32'hFFFF_FFFF);
        chk("n0_reads", 0, 32'(reads_seen), 32'd0);
`ifdef OFLOW_SIM_THRESH_EN
        chk("n0_new_obj", 0, 32'(new_obj), 32'd1);
`else
        chk("n0_new_obj", 0, 32'(new_obj), 32'd0);
`endif

        load4(32'd30, 32'd26, 32'd0, 32'd0, 12'h031);
        run_search(2, 32'd25, -1, 0);
        chk("thr25_best_score", 0, best_score, 32'd26);
`ifdef OFLOW_SIM_THRESH_EN
        chk("thr25_new_obj", 0, 32'(new_obj), 32'd1);
`else
        chk("thr25_new_obj", 0, 32'(new_obj), 32'd0);
`endif
        run_search(2, 32'd26, -1, 0);
        chk("thr26_new_obj", 0, 32'(new_obj), 32'd0);

        load4(32'd50, 32'd20, 32'd70, 32'd30, 12'h011);
        run_search(4, 32'd0, 2, 0);
        chk("restart_done_cycle", 0, 32'(done_seen), 32'd8);
        run_search(4, 32'd0, -1, 3);
        chk("abort_no_done", 0, 32'(done_seen), 32'hFFFF_FFFF);
        load4(32'd60, 32'd61, 32'd7, 32'd62, 12'h041);
        run_search(4, 32'd0, -1, 0);
        chk("after_abort_done_cycle", 0, 32'(done_seen), 32'd8);
        chk("after_abort_best_idx", 0, 32'(best_idx), 32'd2);

        for (int k = 0; k < 16; k++) begin
            sc[k]  = 32'(1000 - 10 * k);
            idv[k] = 12'h100 + 12'(k);
        end
        run_search(20, 32'd0, -1, 0);
        chk("clamp_reads", 0, 32'(reads_seen), 32'd16);
        chk("clamp_done_cycle", 0, 32'(done_seen), 32'd20);
        chk("clamp_best_score", 0, best_score, 32'd850);
        chk("clamp_best_idx", 0, 32'(best_idx), 32'd15);
        chk("clamp_best_id", 0, 32'(best_id), 32'h10F);

        @(negedge clk);
        chk("final_idle_busy", 0, 32'(busy), 32'd0);
        chk("final_idle_done", 0, 32'(done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
